// File: rtl/vt100_response_encoder_pkg.sv
// rtl/vt100_response_encoder_pkg.sv - shared types and ASCII constants for the VT100 response encoder
package vt100_response_encoder_pkg;

  localparam int RESP_SEQ_MAX = 10;

  typedef enum logic [1:0] {
    REP_DSR = 2'd0,
    REP_CPR = 2'd1,
    REP_DA  = 2'd2
  } ReportType_t;

  typedef enum logic [2:0] {
    KEY_CHAR  = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_RIGHT = 3'd3,
    KEY_LEFT  = 3'd4
  } KeyType_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } Cursor_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } State_t;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_SEMI     = 8'h3B;
  localparam logic [7:0] ASCII_QMARK    = 8'h3F;
  localparam logic [7:0] ASCII_DIGIT0   = 8'h30;
  localparam logic [7:0] ASCII_O        = 8'h4F;

endpackage

// File: rtl/vt100_bin_to_ascii_dec.sv
// rtl/vt100_bin_to_ascii_dec.sv - 9-bit binary to up to three ASCII decimal digits
module vt100_bin_to_ascii_dec
  import vt100_response_encoder_pkg::*;
(
  input  logic [8:0] value,
  output logic [7:0] digit_hi,
  output logic [7:0] digit_mid,
  output logic [7:0] digit_lo,
  output logic [1:0] count
);

  always_comb begin
    digit_hi  = ASCII_DIGIT0 + 8'(value / 9'd100);
    digit_mid = ASCII_DIGIT0 + 8'((value / 9'd10) % 9'd10);
    digit_lo  = ASCII_DIGIT0 + 8'(value % 9'd10);
    // count drives leading-zero suppression; a zero value still yields one digit
    if (value >= 9'd100)     count = 2'd3;
    else if (value >= 9'd10) count = 2'd2;
    else                     count = 2'd1;
  end

endmodule

// File: rtl/vt100_response_encoder.sv
// rtl/vt100_response_encoder.sv - encodes DSR/CPR/DA reports and key events into a byte stream (option: VT100_APP_CURSOR_EN)
module vt100_response_encoder
  import vt100_response_encoder_pkg::*;
#(
  parameter int         SEQ_MAX    = RESP_SEQ_MAX,
  parameter logic [7:0] DA_OPTION  = 8'h30,
  parameter int         POS_OFFSET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reportValid,
  input  ReportType_t reportType,
  output logic        reportReady,
  input  logic        keyValid,
  input  KeyType_t    keyType,
  input  logic [7:0]  keyChar,
  output logic        keyReady,
  input  logic        appCursor,
  input  Cursor_t     cursor,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam int IW = $clog2(SEQ_MAX + 1);

  State_t        state, state_next;
  logic [7:0]    seq_buf [SEQ_MAX];
  logic [IW-1:0] len, idx;
  logic [7:0]    seq [SEQ_MAX];
  logic [IW-1:0] seq_len;
  logic          report_fire, key_fire, accept, last_hs;
  logic [7:0]    arrow_intro;
  logic [8:0]    row, col;
  logic [7:0]    row_hi, row_mid, row_lo, col_hi, col_mid, col_lo;
  logic [1:0]    row_cnt, col_cnt;

  assign row = {1'b0, cursor.y} + 9'(POS_OFFSET);
  assign col = {1'b0, cursor.x} + 9'(POS_OFFSET);

  vt100_bin_to_ascii_dec u_row_dec (
    .value(row), .digit_hi(row_hi), .digit_mid(row_mid), .digit_lo(row_lo), .count(row_cnt)
  );
  vt100_bin_to_ascii_dec u_col_dec (
    .value(col), .digit_hi(col_hi), .digit_mid(col_mid), .digit_lo(col_lo), .count(col_cnt)
  );

`ifdef VT100_APP_CURSOR_EN
  assign arrow_intro = appCursor ? ASCII_O : ASCII_LBRACKET;
`else
  logic unused_app_cursor;
  assign unused_app_cursor = appCursor;
  assign arrow_intro       = ASCII_LBRACKET;
`endif

  // reports win over keys; a waiting key just sees keyReady low
  assign reportReady = (state == IDLE);
  assign keyReady    = (state == IDLE) && !reportValid;
  assign report_fire = reportValid && reportReady;
  assign key_fire    = keyValid && keyReady;
  assign accept      = report_fire || key_fire;

  assign txValid = (state == EMIT);
  assign txData  = txValid ? seq_buf[idx] : 8'h00;
  assign last_hs = txValid && txReady && (idx == len - IW'(1));

  always_comb begin
    seq     = '{default: 8'h00};
    seq_len = '0;
    if (report_fire) begin
      case (reportType)
        REP_DSR: begin
          seq[0] = ASCII_ESC; seq[1] = ASCII_LBRACKET; seq[2] = ASCII_DIGIT0; seq[3] = 8'h6E;
          seq_len = IW'(4);
        end
        REP_CPR: begin
          seq[0] = ASCII_ESC; seq[1] = ASCII_LBRACKET;
          seq_len = IW'(2);
          if (row_cnt == 2'd3) begin seq[seq_len] = row_hi;  seq_len = seq_len + IW'(1); end
          if (row_cnt >= 2'd2) begin seq[seq_len] = row_mid; seq_len = seq_len + IW'(1); end
          seq[seq_len] = row_lo;     seq_len = seq_len + IW'(1);
          seq[seq_len] = ASCII_SEMI; seq_len = seq_len + IW'(1);
          if (col_cnt == 2'd3) begin seq[seq_len] = col_hi;  seq_len = seq_len + IW'(1); end
          if (col_cnt >= 2'd2) begin seq[seq_len] = col_mid; seq_len = seq_len + IW'(1); end
          seq[seq_len] = col_lo;     seq_len = seq_len + IW'(1);
          seq[seq_len] = 8'h52;      seq_len = seq_len + IW'(1);
        end
        REP_DA: begin
          seq[0] = ASCII_ESC; seq[1] = ASCII_LBRACKET; seq[2] = ASCII_QMARK;
          seq[3] = ASCII_DIGIT0 + 8'd1; seq[4] = ASCII_SEMI; seq[5] = DA_OPTION; seq[6] = 8'h63;
          seq_len = IW'(7);
        end
        default: seq_len = '0;
      endcase
    end else if (key_fire) begin
      seq[0] = ASCII_ESC;
      seq[1] = arrow_intro;
      seq_len = IW'(3);
      case (keyType)
        KEY_CHAR:  begin seq[0] = keyChar; seq[1] = 8'h00; seq_len = IW'(1); end
        KEY_UP:    seq[2] = 8'h41;
        KEY_DOWN:  seq[2] = 8'h42;
        KEY_RIGHT: seq[2] = 8'h43;
        KEY_LEFT:  seq[2] = 8'h44;
        default:   begin seq[0] = 8'h00; seq[1] = 8'h00; seq_len = '0; end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && (seq_len != '0)) state_next = EMIT;
      EMIT: if (last_hs) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      for (int i = 0; i < SEQ_MAX; i++) seq_buf[i] <= 8'h00;
    end else begin
      state <= state_next;
      if (accept) begin
        seq_buf <= seq;
        len     <= seq_len;
        idx     <= '0;
      end else if (txValid && txReady) begin
        idx <= last_hs ? '0 : idx + IW'(1);
      end
    end
  end

endmodule
